max6675_scheduler: RTL and testbench
====================================

MAX6675_SCHEDULER -- requirements
Module: max6675_scheduler

Interface
REQ-001 The block SHALL have parameter PERIOD_CYCLES, default 12500000, giving the automatic sample period in clk cycles (250 ms at 50 MHz).
REQ-002 The block SHALL have parameter HOLDOFF_CYCLES, default 11000000, giving the minimum number of clk cycles between a capture and the next start (220 ms).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 20000, giving the maximum number of clk cycles allowed from start to finish.
REQ-004 The block SHALL have the following ports; there is one clock, and the reset is asynchronous and active-low:
  clk  in  1  system clock
  reset_n  in  1  asynchronous active-low reset
  enable  in  1  enables periodic sampling
  req  in  1  single-cycle one-shot sample request
  dec_idle  in  1  decoder idle flag
  dec_finish  in  1  decoder finish flag
  dec_data  in  16  decoder frame word
  dec_start  out  1  decoder start strobe
  busy  out  1  transaction in progress
  done  out  1  one-cycle pulse per completed attempt
  temp_valid  out  1  one-cycle pulse; temp_q updated
  temp_q  out  12  dec_data[14:3], in 0.25 °C units
  tc_open  out  1  dec_data[2] of the last capture
  frame_err  out  1  dec_data[15] or dec_data[1] set in the last capture
  timeout_err  out  1  sticky timeout flag

Function
REQ-005 The state machine SHALL have states IDLE, START, WAIT_FINISH, CAPTURE and HOLDOFF.
REQ-006 A 24-bit period counter SHALL reload to PERIOD_CYCLES-1 when enable=0 and SHALL decrement when enable=1; reaching 0 SHALL set the pending flag and reload the counter.
REQ-007 req=1 SHALL set the pending flag; a simultaneous period tick and req SHALL set pending once; requests arriving while pending=1 SHALL coalesce.
REQ-008 IDLE -> START SHALL occur when pending=1 and dec_idle=1; pending SHALL clear on that transition; if dec_idle=0, the block SHALL remain in IDLE.
REQ-009 START SHALL assert dec_start and move to WAIT_FINISH on the first cycle dec_idle is sampled 0; the timeout counter SHALL clear on entry to START.
REQ-010 In WAIT_FINISH, dec_start SHALL be 0; dec_finish=1 SHALL move to CAPTURE.
REQ-011 In CAPTURE, the block SHALL latch dec_data, update tc_open and frame_err, pulse done, and clear timeout_err; it SHALL update temp_q and pulse temp_valid only if tc_open=0 and frame_err=0; it SHALL then go to HOLDOFF.
REQ-012 If the timeout counter reaches TIMEOUT_CYCLES in START or WAIT_FINISH, the block SHALL set timeout_err, pulse done, leave temp_q unchanged, and go to HOLDOFF.
REQ-013 HOLDOFF SHALL count HOLDOFF_CYCLES cycles and then return to IDLE; pending requests SHALL be accepted but not served during HOLDOFF.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 enable falling mid-transaction SHALL NOT abort the transaction; the transaction SHALL complete normally.
REQ-016 All outputs SHALL be registered; done and temp_valid SHALL be exactly one cycle wide.

Reset
REQ-017 While reset_n=0, the block SHALL hold state=IDLE, pending=0, all counters=0 (period counter=PERIOD_CYCLES-1), dec_start=0, busy=0, done=0, temp_valid=0, temp_q=0, tc_open=0, frame_err=0 and timeout_err=0.
REQ-018 A reset asserted mid-transaction SHALL take effect immediately; after release, the block SHALL wait for dec_idle=1 before issuing a new start.

Verification (PERIOD=100, HOLDOFF=20, TIMEOUT=50)
REQ-019 enable=1, decoder model finishes with 16'h0C80 -> dec_start asserted after 100 cycles; temp_q=12'h190 (100.00 °C); temp_valid and done pulse once; tc_open=0.
REQ-020 dec_data=16'h0C84 -> done pulses, tc_open=1, temp_valid stays 0, temp_q keeps its previous value.
REQ-021 Decoder never raises finish -> timeout_err=1 at 50 cycles after START, done pulses; the next good capture clears timeout_err.
REQ-022 req pulsed 3 times during one busy period -> exactly one further transaction, starting no earlier than 20 cycles after CAPTURE.
REQ-023 reset_n low during WAIT_FINISH while dec_idle=0 -> all outputs at reset values; after release, no dec_start until dec_idle=1.
REQ-024 enable=0 and req=0 for 1000 cycles -> dec_start never asserted and busy=0 throughout.

Source files
------------

// File: rtl/max6675_scheduler.sv
// rtl/max6675_scheduler.sv - MAX6675 sample scheduler: periodic/one-shot starts, capture, holdoff and timeout
module max6675_scheduler #(
  parameter int PERIOD_CYCLES  = 12500000,
  parameter int HOLDOFF_CYCLES = 11000000,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        req,
  input  logic        dec_idle,
  input  logic        dec_finish,
  input  logic [15:0] dec_data,
  output logic        dec_start,
  output logic        busy,
  output logic        done,
  output logic        temp_valid,
  output logic [11:0] temp_q,
  output logic        tc_open,
  output logic        frame_err,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_FINISH,
    CAPTURE,
    HOLDOFF
  } state_e;

  localparam logic [23:0] PER_RELOAD = 24'(PERIOD_CYCLES - 1);
  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLDOFF_CYCLES - 1);

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic [23:0] per_cnt_q;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] hold_q, hold_d;
  logic        tick;
  logic        accept;

  logic        dec_start_q, dec_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        temp_valid_q, temp_valid_d;
  logic [11:0] temp_val_q, temp_val_d;
  logic        tc_open_q, tc_open_d;
  logic        frame_err_q, frame_err_d;
  logic        timeout_err_q, timeout_err_d;

  // Bit 0 of the MAX6675 frame carries no information.
  logic        unused_bit;
  assign unused_bit = dec_data[0];

  assign tick = enable && (per_cnt_q == 24'd0);

  // Period counter: held at reload while disabled, reloads on each tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt_q <= PER_RELOAD;
    end else if (!enable || per_cnt_q == 24'd0) begin
      per_cnt_q <= PER_RELOAD;
    end else begin
      per_cnt_q <= per_cnt_q - 24'd1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      tmo_q         <= 32'd0;
      hold_q        <= 32'd0;
      dec_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      temp_valid_q  <= 1'b0;
      temp_val_q    <= 12'd0;
      tc_open_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      tmo_q         <= tmo_d;
      hold_q        <= hold_d;
      dec_start_q   <= dec_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      temp_valid_q  <= temp_valid_d;
      temp_val_q    <= temp_val_d;
      tc_open_q     <= tc_open_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic; capture results are computed on entry to CAPTURE so they are visible there.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    hold_d        = hold_q;
    accept        = 1'b0;
    done_d        = 1'b0;
    temp_valid_d  = 1'b0;
    temp_val_d    = temp_val_q;
    tc_open_d     = tc_open_q;
    frame_err_d   = frame_err_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (pending_q && dec_idle) begin
          state_d = START;
          accept  = 1'b1;
          tmo_d   = 32'd0;
        end
      end
      START: begin
        if (tmo_q == TMO_LAST) begin
          state_d       = HOLDOFF;
          hold_d        = 32'd0;
          timeout_err_d = 1'b1;
          done_d        = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
          if (!dec_idle) begin
            state_d = WAIT_FINISH;
          end
        end
      end
      WAIT_FINISH: begin
        if (dec_finish) begin
          state_d       = CAPTURE;
          tc_open_d     = dec_data[2];
          frame_err_d   = dec_data[15] | dec_data[1];
          done_d        = 1'b1;
          timeout_err_d = 1'b0;
          if (!dec_data[2] && !dec_data[15] && !dec_data[1]) begin
            temp_val_d   = dec_data[14:3];
            temp_valid_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d       = HOLDOFF;
          hold_d        = 32'd0;
          timeout_err_d = 1'b1;
          done_d        = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      CAPTURE: begin
        state_d = HOLDOFF;
        hold_d  = 32'd0;
      end
      HOLDOFF: begin
        if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A tick or request after acceptance re-arms; duplicates coalesce into one flag.
    pending_d   = (pending_q && !accept) || tick || req;
    dec_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);
  end

  assign dec_start   = dec_start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign temp_valid  = temp_valid_q;
  assign temp_q      = temp_val_q;
  assign tc_open     = tc_open_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_max6675_scheduler.sv
// tb/tb_max6675_scheduler.sv - directed self-checking bench for max6675_scheduler
module tb_max6675_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        req;
  logic        dec_idle;
  logic        dec_finish;
  logic [15:0] dec_data;
  logic        dec_start;
  logic        busy;
  logic        done;
  logic        temp_valid;
  logic [11:0] temp_q;
  logic        tc_open;
  logic        frame_err;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  int n;
  logic bad;

  always #5 clk = ~clk;

  max6675_scheduler #(
    .PERIOD_CYCLES (100),
    .HOLDOFF_CYCLES(20),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .req        (req),
    .dec_idle   (dec_idle),
    .dec_finish (dec_finish),
    .dec_data   (dec_data),
    .dec_start  (dec_start),
    .busy       (busy),
    .done       (done),
    .temp_valid (temp_valid),
    .temp_q     (temp_q),
    .tc_open    (tc_open),
    .frame_err  (frame_err),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output int cnt);
    cnt = 0;
    while (dec_start !== 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy !== 1'b0 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic pulse_req();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  // Decoder already busy (dec_idle=0); after 'delay' cycles it finishes with word d.
  // Optionally pulses req 'reqs' times while waiting. Returns on the CAPTURE sample.
  task automatic finish_frame(input logic [15:0] d, input int delay, input int reqs);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      req = (i < 2 * reqs) && (i % 2 == 0);
    end
    req        = 1'b0;
    dec_finish = 1'b1;
    dec_data   = d;
    @(negedge clk);
    dec_finish = 1'b0;
    dec_idle   = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    req        = 1'b0;
    dec_idle   = 1'b1;
    dec_finish = 1'b0;
    dec_data   = 16'h0000;
    repeat (3) @(negedge clk);

    check("rst_dec_start",   32'(dec_start),   32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_done",        32'(done),        32'd0);
    check("rst_temp_valid",  32'(temp_valid),  32'd0);
    check("rst_temp_q",      32'(temp_q),      32'd0);
    check("rst_tc_open",     32'(tc_open),     32'd0);
    check("rst_frame_err",   32'(frame_err),   32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);

    reset_n = 1'b1;

    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (dec_start !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("idle_quiet_1000", 32'(bad), 32'd0);

    enable = 1'b1;
    wait_start(n);
    check("period_latency", 32'(n), 32'd101);
    enable   = 1'b0;
    dec_idle = 1'b0;
    @(negedge clk);
    check("start_one_cycle", 32'(dec_start), 32'd0);
    check("busy_in_wait",    32'(busy),      32'd1);
    finish_frame(16'h0C80, 3, 0);
    check("good_done",       32'(done),       32'd1);
    check("good_temp_valid", 32'(temp_valid), 32'd1);
    check("good_temp_q",     32'(temp_q),     32'h190);
    check("good_tc_open",    32'(tc_open),    32'd0);
    check("good_frame_err",  32'(frame_err),  32'd0);
    @(negedge clk);
    check("done_width",       32'(done),       32'd0);
    check("temp_valid_width", 32'(temp_valid), 32'd0);
    check("busy_holdoff",     32'(busy),       32'd1);
    wait_idle(n);
    check("holdoff_len", 32'(n), 32'd20);

    pulse_req();
    wait_start(n);
    check("req_latency", 32'(n), 32'd1);
    dec_idle = 1'b0;
    finish_frame(16'h0C84, 4, 0);
    check("open_done",       32'(done),       32'd1);
    check("open_tc_open",    32'(tc_open),    32'd1);
    check("open_temp_valid", 32'(temp_valid), 32'd0);
    check("open_temp_q",     32'(temp_q),     32'h190);
    check("open_frame_err",  32'(frame_err),  32'd0);
    wait_idle(n);

    pulse_req();
    wait_start(n);
    dec_idle = 1'b0;
    finish_frame(16'h8C80, 2, 0);
    check("ferr_done",       32'(done),       32'd1);
    check("ferr_frame_err",  32'(frame_err),  32'd1);
    check("ferr_tc_open",    32'(tc_open),    32'd0);
    check("ferr_temp_valid", 32'(temp_valid), 32'd0);
    check("ferr_temp_q",     32'(temp_q),     32'h190);
    wait_idle(n);

    pulse_req();
    wait_start(n);
    dec_idle = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency",  32'(n),           32'd50);
    check("timeout_err_set",  32'(timeout_err), 32'd1);
    check("timeout_temp_q",   32'(temp_q),      32'h190);
    check("timeout_no_valid", 32'(temp_valid),  32'd0);
    dec_idle = 1'b1;
    wait_idle(n);

    pulse_req();
    wait_start(n);
    dec_idle = 1'b0;
    finish_frame(16'h0FA0, 8, 3);
    check("clear_timeout_err", 32'(timeout_err), 32'd0);
    check("clear_temp_q",      32'(temp_q),      32'h1F4);
    check("clear_temp_valid",  32'(temp_valid),  32'd1);
    wait_start(n);
    check("coalesce_gap", 32'(n), 32'd22);
    dec_idle = 1'b0;
    finish_frame(16'h0C80, 3, 0);
    check("coalesce_temp_q", 32'(temp_q), 32'h190);
    bad = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (dec_start !== 1'b0) bad = 1'b1;
    end
    check("coalesce_single", 32'(bad),  32'd0);
    check("coalesce_idle",   32'(busy), 32'd0);

    pulse_req();
    wait_start(n);
    dec_idle = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy",        32'(busy),        32'd0);
    check("mid_rst_dec_start",   32'(dec_start),   32'd0);
    check("mid_rst_done",        32'(done),        32'd0);
    check("mid_rst_temp_valid",  32'(temp_valid),  32'd0);
    check("mid_rst_temp_q",      32'(temp_q),      32'd0);
    check("mid_rst_tc_open",     32'(tc_open),     32'd0);
    check("mid_rst_frame_err",   32'(frame_err),   32'd0);
    check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pulse_req();
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (dec_start !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("post_rst_wait_idle", 32'(bad), 32'd0);
    dec_idle = 1'b1;
    wait_start(n);
    check("post_rst_start", 32'(n), 32'd1);
    dec_idle = 1'b0;
    finish_frame(16'h0C80, 2, 0);
    check("post_rst_temp_valid", 32'(temp_valid), 32'd1);
    check("post_rst_temp_q",     32'(temp_q),     32'h190);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
